// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and receiver state encoding, shared with the
// VGA controller so both sides agree on one set of numbers.
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    H_LOCK = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// Registers one active-low sync input and flags its falling and rising edges
// relative to the previous registered sample. Both registers idle high.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic fall,
  output logic rise
);
  logic cur, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      cur  <= level;
      prev <= cur;
    end
  end

  assign fall = prev & ~cur;
  assign rise = ~prev & cur;
endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates from an incoming VGA sync stream, locking first to
// the line timing and then to the frame timing, and flags sync timing errors.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [2:0] RGB,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [2:0] pixel_rgb,
  output logic       pixel_valid,
  output logic       locked,
  output logic       frame_start,
  output logic       h_err,
  output logic       v_err
);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] X_HS0  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] X_HS1  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] Y_VS0  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] Y_VS1  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic        h_fall, h_rise, v_fall, v_rise;
  logic [2:0]  rgb_s;
  sync_state_t state, nstate;
  logic [9:0]  x_cnt, y_cnt, cur_x, cur_y;
  logic        have_fall, h_bad, v_bad, lock_next, in_active;

  sync_edge_detect u_h_edge (.clk(clk), .reset(reset), .level(h_sync), .fall(h_fall), .rise(h_rise));
  sync_edge_detect u_v_edge (.clk(clk), .reset(reset), .level(v_sync), .fall(v_fall), .rise(v_rise));

  always_comb begin
    // A sync fall pins the current sample to the start of its sync pulse.
    cur_x = h_fall ? X_HS0 : x_cnt;
    cur_y = (v_fall && state == H_LOCK) ? Y_VS0 : y_cnt;

    h_bad = (state != SEARCH) &&
            ((h_fall != (x_cnt == X_HS0)) || (h_rise && x_cnt != X_HS1));
    v_bad = 1'b0;
    if (state == H_LOCK)
      v_bad = v_fall && (x_cnt != '0);
    else if (state == LOCKED)
      v_bad = (v_fall != (y_cnt == Y_VS0 && x_cnt == '0)) ||
              (v_rise != (y_cnt == Y_VS1 && x_cnt == '0));

    nstate = state;
    if (h_bad)
      nstate = SEARCH;
    else
      case (state)
        SEARCH:  if (h_fall && have_fall && x_cnt == X_HS0) nstate = H_LOCK;
        H_LOCK:  if (v_fall && x_cnt == '0) nstate = LOCKED;
        LOCKED:  if (v_bad) nstate = H_LOCK;
        default: nstate = SEARCH;
      endcase

    lock_next = (nstate == LOCKED);
    in_active = (cur_x < X_ACT) && (cur_y < Y_ACT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      x_cnt       <= '0;
      y_cnt       <= '0;
      have_fall   <= 1'b0;
      rgb_s       <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
      pixel_valid <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      state <= nstate;
      rgb_s <= RGB;
      x_cnt <= (cur_x == X_LAST) ? '0 : cur_x + 10'd1;
      if (cur_x == X_LAST)
        y_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + 10'd1;
      else
        y_cnt <= cur_y;
      // Remembers a fall only until the column where the next one is due.
      have_fall   <= h_fall | (have_fall & (x_cnt != X_HS0));
      pixel_x     <= cur_x;
      pixel_y     <= cur_y;
      pixel_valid <= lock_next && in_active;
      pixel_rgb   <= (lock_next && in_active) ? rgb_s : 3'd0;
      locked      <= lock_next;
      frame_start <= lock_next && cur_x == '0 && cur_y == '0;
      h_err       <= h_bad;
      v_err       <= v_bad;
    end
  end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Drives a scaled-down VGA sync generator (with faults) into the receiver and
// compares every output cycle with a position-index reference model.
module tb_vga_sync_receiver;
  localparam int HA = 16, HF = 4, HSW = 8, HB = 4, HT = HA + HF + HSW + HB;
  localparam int VA = 12, VF = 2, VSW = 2, VB = 3, VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int HS0 = HA + HF, HS1 = HS0 + HSW, VS0 = VA + VF, VS1 = VS0 + VSW;

  logic       clk = 1'b0, reset = 1'b1, h_sync = 1'b1, v_sync = 1'b1;
  logic [2:0] RGB = '0;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] pixel_rgb;
  logic       pixel_valid, locked, frame_start, h_err, v_err;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .RGB(RGB),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
    .pixel_valid(pixel_valid), .locked(locked), .frame_start(frame_start),
    .h_err(h_err), .v_err(v_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x, y;
    logic [2:0] rgb;
    logic       vld, lk, fs, he, ve;
  } obs_t;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the recovered position is one linear index into the frame.
  int m_st, m_p, m_t, m_last;
  bit m_ph, m_pv;

  function automatic void model_reset();
    m_st = 0; m_p = 0; m_t = 0; m_last = -100000; m_ph = 1'b1; m_pv = 1'b1;
  endfunction

  function automatic obs_t model_step(input bit h, input bit v, input logic [2:0] c);
    obs_t o;
    bit hf, hr, vf, vr, he, ve;
    int col, row, nst;
    hf = m_ph & ~h; hr = ~m_ph & h; vf = m_pv & ~v; vr = ~m_pv & v;
    col = m_p % HT; row = m_p / HT;
    he = (m_st != 0) && ((hf != (col == HS0)) || (hr && col != HS1));
    ve = 1'b0;
    if (m_st == 1) ve = vf && col != 0;
    if (m_st == 2) ve = (vf != (row == VS0 && col == 0)) || (vr != (row == VS1 && col == 0));
    nst = m_st;
    if (he) nst = 0;
    else if (m_st == 0 && hf && (m_t - m_last) == HT) nst = 1;
    else if (m_st == 1 && vf && col == 0) nst = 2;
    else if (m_st == 2 && ve) nst = 1;
    if (hf) col = HS0;
    if (vf && m_st == 1) row = VS0;
    o.x = 10'(col); o.y = 10'(row);
    o.lk = (nst == 2);
    o.vld = o.lk && col < HA && row < VA;
    o.fs = o.lk && col == 0 && row == 0;
    o.rgb = o.vld ? c : 3'd0;
    o.he = he; o.ve = ve;
    m_p = (row * HT + col + 1) % FT;
    if (hf) m_last = m_t;
    m_t++; m_ph = h; m_pv = v; m_st = nst;
    return o;
  endfunction

  obs_t q[$];
  int cyc = 0, base = 0, last_fs = -1, vld_since = 0, first_lock = -1;
  int herr_n = 0, verr_n = 0, fs_n = 0, verr_y = -1;
  bit rgb_const = 1'b0, hold_h = 1'b0, glitch = 1'b0;
  int vlow = VSW;
  int gx = 0, gy = 0;

  task automatic clr();
    herr_n = 0; verr_n = 0; fs_n = 0; verr_y = -1; first_lock = -1; base = cyc;
  endtask

  task automatic tick(input bit h, input bit v, input logic [2:0] c, input bit rst);
    obs_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("flags", 32'({pixel_valid, locked, frame_start, h_err, v_err}),
                   32'({e.vld, e.lk, e.fs, e.he, e.ve}));
      chk("xy", 32'({pixel_x, pixel_y}), 32'({e.x, e.y}));
      chk("rgb", 32'(pixel_rgb), 32'(e.rgb));
      if (rgb_const && pixel_valid) chk("rgb_011", 32'(pixel_rgb), 32'd3);
      if (h_err) herr_n++;
      if (v_err) begin verr_n++; verr_y = int'(pixel_y); end
      if (locked && first_lock < 0) first_lock = cyc;
      if (!locked) last_fs = -1;
      if (frame_start) begin
        fs_n++;
        if (last_fs >= 0) begin
          chk("fs_period", cyc - last_fs, FT);
          chk("valid_per_frame", vld_since, HA * VA);
        end
        last_fs = cyc; vld_since = 0;
      end
      if (pixel_valid) vld_since++;
    end
    reset = rst; h_sync = h; v_sync = v; RGB = c;
    cyc++;
    if (rst) begin
      q.delete();
      q.push_back('0);
      model_reset();
      q.push_back(model_step(1'b1, 1'b1, 3'd0));
    end else begin
      q.push_back(model_step(h, v, c));
    end
  endtask

  task automatic pins(output bit h, output bit v, output logic [2:0] c);
    h = hold_h || !(gx >= HS0 && gx < HS1);
    v = !(gy >= VS0 && gy < VS0 + vlow);
    c = (rgb_const && gx < HA && gy < VA) ? 3'b011 : 3'($urandom);
    if (glitch && $urandom_range(0, 199) == 0) h = ~h;
    if (glitch && $urandom_range(0, 199) == 0) v = ~v;
  endtask

  task automatic adv();
    gx++;
    if (gx == HT) begin gx = 0; gy = (gy == VT - 1) ? 0 : gy + 1; end
  endtask

  task automatic gen(input int n);
    bit h, v;
    logic [2:0] c;
    for (int i = 0; i < n; i++) begin
      pins(h, v, c); tick(h, v, c, 1'b0); adv();
    end
  endtask

  task automatic gen_until(input int x, input int y);
    for (int i = 0; i <= FT && !(gx == x && gy == y); i++) gen(1);
  endtask

  task automatic reset_here();
    bit h, v;
    logic [2:0] c;
    pins(h, v, c); tick(h, v, c, 1'b1); adv();
  endtask

  initial begin
    model_reset();
    tick(1'b1, 1'b1, 3'd0, 1'b1);

    // clean stream from reset, constant colour in the active area
    rgb_const = 1'b1; clr(); gen(3 * FT); rgb_const = 1'b0;
    chk("lock_in_frame1", 32'(first_lock >= 0 && first_lock - base <= FT), 1);
    chk("clean_herr", herr_n, 0);
    chk("clean_verr", verr_n, 0);
    chk("clean_fs_count", fs_n, 2);

    // one line a clock short
    gen_until(5, 3); gx = 6; clr(); gen(2 * FT);
    chk("short_herr", herr_n, 1);
    chk("short_verr", verr_n, 0);
    chk("short_relock", 32'(locked), 1);

    // vertical sync held low one line too long
    gen_until(0, 0); vlow = VSW + 1; clr(); gen(FT); vlow = VSW;
    chk("vlong_verr", verr_n, 1);
    chk("vlong_verr_row", verr_y, VS1);
    chk("vlong_herr", herr_n, 0);
    chk("vlong_unlocked", 32'(locked), 0);
    gen(FT);
    chk("vlong_relock", 32'(locked), 1);

    // single-cycle reset mid-frame
    gen_until(10, 6); clr(); reset_here(); gen(FT);
    chk("rst_relock", 32'(locked), 1);
    chk("rst_errs", herr_n + verr_n, 0);

    // horizontal sync stuck high for two lines after reset
    gen_until(0, 2); reset_here(); hold_h = 1'b1; clr(); gen(2 * HT);
    chk("hold_herr", herr_n, 0);
    chk("hold_search", 32'(locked), 0);
    hold_h = 1'b0; gen(2 * FT);
    chk("hold_relock", 32'(locked), 1);

    // random sync glitches, then recovery
    glitch = 1'b1; gen(3 * FT); glitch = 1'b0; gen(3 * FT);
    chk("glitch_relock", 32'(locked), 1);

    gen(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 (line total 800); V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (frame total 525); all counts in pixel clocks and lines.
REQ-002 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  pixel clock; all logic samples on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 h_sync  input  1  horizontal sync from the VGA source, active-low.
REQ-006 v_sync  input  1  vertical sync from the VGA source, active-low.
REQ-007 RGB  input  3  pixel colour from the VGA source.
REQ-008 pixel_x  output  10  recovered column of pixel_rgb.
REQ-009 pixel_y  output  10  recovered row of pixel_rgb.
REQ-010 pixel_rgb  output  3  captured colour, aligned with pixel_x/pixel_y.
REQ-011 pixel_valid  output  1  high when locked and pixel_x<640 and pixel_y<480.
REQ-012 locked  output  1  high in state LOCKED only.
REQ-013 frame_start  output  1  one-cycle pulse when locked and pixel_x=0 and pixel_y=0.
REQ-014 h_err, v_err  output  1 each  one-cycle error pulses.

Function
REQ-015 Inputs SHALL pass one register stage (S). The S-stage sample is the "current sample". Outputs SHALL be registered from S, giving a latency of 2 clocks from pins to outputs.
REQ-016 h_fall SHALL be detected when the S-stage h_sync is 0 and the previous S-stage value was 1. v_fall SHALL be detected the same way on v_sync.
REQ-017 x_cnt SHALL increment each clock and wrap from 799 to 0. On h_fall, the current sample SHALL be treated as column 656, so x_cnt is loaded with 657 for the next sample.
REQ-018 y_cnt SHALL increment when x_cnt wraps to 0, and SHALL wrap from 524 to 0. On v_fall in H_LOCK, the current sample SHALL be treated as row 490.
REQ-019 The FSM SHALL have states SEARCH, H_LOCK and LOCKED, all 0-based.
REQ-020 SEARCH -> H_LOCK SHALL occur on the second consecutive h_fall exactly 800 clocks after the previous one. In SEARCH, x_cnt free-runs and no check is made.
REQ-021 H_LOCK -> LOCKED SHALL occur on v_fall coincident with x_cnt=0. A v_fall at any other x_cnt SHALL pulse v_err and keep the FSM in H_LOCK.
REQ-022 Horizontal checks SHALL apply in H_LOCK and LOCKED. h_fall at any column other than 656, a missing h_fall at column 656, or an h_sync rise at any column other than 752 SHALL each pulse h_err and move the FSM to SEARCH.
REQ-023 Vertical checks SHALL apply in LOCKED. v_fall at any row other than 490, a missing v_fall at row 490, or a v_sync rise at any row other than 492 (x_cnt=0) SHALL each pulse v_err and move the FSM to H_LOCK.
REQ-024 If an h error and a v error occur in the same cycle, both flags SHALL pulse and SEARCH SHALL take priority.
REQ-025 pixel_valid, locked and frame_start SHALL go low in the same output cycle as the error pulse.
REQ-026 The RGB value of a sample SHALL NOT affect lock or error detection.

Reset
REQ-027 On reset, the FSM SHALL enter SEARCH, and x_cnt, y_cnt, pixel_x, pixel_y and pixel_rgb SHALL be 0.
REQ-028 On reset, the S-stage sync registers and their edge history SHALL be set to 1 (idle), and pixel_valid, locked, frame_start, h_err and v_err SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard lock; re-acquisition SHALL follow REQ-020 and REQ-021.

Structure
REQ-030 All timing constants and the FSM state encoding SHALL live in the shared package vga_timing_pkg. The existing VGA controller SHALL use the same constants.
REQ-031 One sub-module, sync_edge_detect, SHALL provide the input register, previous-value register and fall/rise pulses. It SHALL be instantiated once for h_sync and once for v_sync.

Verification
REQ-032 Scenario: drive the standard 800x525 generator output for 2 frames from reset. Required: locked rises during frame 1, then frame_start pulses every 420000 clocks with zero h_err/v_err.
REQ-033 Scenario: generator RGB=3'b011 in the active area. Required: pixel_rgb=3'b011 whenever pixel_valid=1, and 3'b000 otherwise; exactly 307200 valid cycles per frame.
REQ-034 Scenario: while locked, shorten one line to 799 clocks. Required: a single h_err pulse, locked low, and h_err=0 thereafter.
REQ-035 Scenario: while locked, hold v_sync low for 3 lines. Required: v_err at row 492 and FSM in H_LOCK; locked returns at the next correct v_fall.
REQ-036 Scenario: assert reset for 1 clock at pixel (300,200) while locked. Required: all outputs 0 the next cycle, and lock regained after the next v_fall.
REQ-037 Scenario: h_sync held high for 1600 clocks. Required: FSM stays in SEARCH with no h_err.
